// File: rtl/chacha_pkg.sv
// ---------------------------------------------------------------------------
// chacha_pkg
// Shared types and constants for the ChaCha20 keystream path.
//   word_t          32-bit ChaCha20 state/counter word
//   KS_BLK_BYTES    bytes produced by one ChaCha20 block
//   KS_NUM_MATRICES default blocks held by one concatenator buffer
//   KS_BYTES_W      width of the buffer byte-count field
//   ks_state_t      keystream sequencer FSM states
// ---------------------------------------------------------------------------
package chacha_pkg;

    typedef logic [31:0] word_t;

    localparam int KS_BLK_BYTES    = 64;
    localparam int KS_NUM_MATRICES = 2;
    localparam int KS_BYTES_W      = $clog2(KS_NUM_MATRICES * KS_BLK_BYTES + 1);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT_CORE,
        LOAD,
        SERIAL,
        PRESENT,
        CLEAR
    } ks_state_t;

endpackage

// File: rtl/chacha_keystream_sequencer_if.sv
// ---------------------------------------------------------------------------
// chacha_keystream_sequencer_if
// Buffer handshake between the keystream sequencer and its consumer.
//   ks_valid  buffer ready for the consumer        (master -> slave)
//   ks_bytes  valid bytes in the buffer            (master -> slave)
//   ks_last   final buffer of the stream           (master -> slave)
//   ks_ready  consumer accepts the buffer          (slave -> master)
// Modports: master (sequencer side), slave (consumer side).
// ---------------------------------------------------------------------------
interface chacha_keystream_sequencer_if
    import chacha_pkg::*;
#(
    parameter int BYTES_W = KS_BYTES_W
);
    logic               ks_valid;
    logic               ks_ready;
    logic [BYTES_W-1:0] ks_bytes;
    logic               ks_last;

    modport master (output ks_valid, output ks_bytes, output ks_last, input ks_ready);
    modport slave  (input ks_valid, input ks_bytes, input ks_last, output ks_ready);
endinterface

// File: rtl/chacha_keystream_sequencer_ctr.sv
// ---------------------------------------------------------------------------
// ks_ctr_gen
// 32-bit ChaCha20 block counter.
//   clk, rst   clock, synchronous active-high reset (count -> 0)
//   load       load load_val (has priority over inc)
//   load_val   initial counter value
//   inc        advance the counter by one
//   count      current counter value (registered)
//   wrap_pend  count is 0xFFFFFFFF, so the next increment wraps
// ---------------------------------------------------------------------------
module ks_ctr_gen
    import chacha_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  load,
    input  word_t load_val,
    input  logic  inc,
    output word_t count,
    output logic  wrap_pend
);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (inc) begin
            count <= count + 32'd1;
        end
    end

    assign wrap_pend = (count == 32'hFFFF_FFFF);

endmodule

// File: rtl/chacha_keystream_sequencer.sv
// ---------------------------------------------------------------------------
// chacha_keystream_sequencer
// Requests ChaCha20 blocks with an incrementing counter, loads each result
// into the serialiser, tracks the 64 bytes it emits into the concatenator
// and presents each filled buffer (up to NUM_MATRICES blocks) downstream.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   start           start pulse (IDLE only); init_counter, num_blocks
//   abort           terminate the stream from any busy state
//   core_start/core_counter/core_done   ChaCha20 core request/response
//   load_en         serialiser load pulse
//   concat_en       serialiser byte strobe; concat_full concatenator full
//   concat_clr      concatenator clear pulse
//   ks              buffer handshake (master modport)
//   busy, done, err_ovf   status (err_ovf sticky on counter wrap)
// Build option: CHACHA_KS_PREFETCH_EN requests the next block while the
// current buffer is being presented.
// ---------------------------------------------------------------------------
module chacha_keystream_sequencer
    import chacha_pkg::*;
#(
    parameter int NUM_MATRICES = KS_NUM_MATRICES
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  word_t       init_counter,
    input  logic [15:0] num_blocks,
    input  logic        abort,
    output logic        core_start,
    output word_t       core_counter,
    input  logic        core_done,
    output logic        load_en,
    input  logic        concat_en,
    input  logic        concat_full,
    output logic        concat_clr,
    chacha_keystream_sequencer_if.master ks,
    output logic        busy,
    output logic        done,
    output logic        err_ovf
);

    localparam int BLK_BYTES = KS_BLK_BYTES;
    localparam int NO_REG    = BLK_BYTES * NUM_MATRICES;
    localparam int BYTES_W   = $clog2(NO_REG + 1);
    localparam int BLK_W     = $clog2(NUM_MATRICES + 1);

    ks_state_t          state;
    logic [BLK_W-1:0]   blk_in_buf;
    logic [BLK_W-1:0]   blk_next;
    logic [15:0]        blocks_left;
    logic [5:0]         byte_cnt;
    logic               last_buf;
    logic               ks_valid_q;
    logic               ks_last_q;
    logic [BYTES_W-1:0] ks_bytes_q;
    logic               ctr_load;
    logic               ctr_inc;
    logic               ctr_wrap_pend;
    logic               last_byte;
    logic               wrap_now;
    logic               last_now;
    logic               buf_full;
`ifdef CHACHA_KS_PREFETCH_EN
    logic               pend;
`endif

    ks_ctr_gen u_ctr (
        .clk       (clk),
        .rst       (rst),
        .load      (ctr_load),
        .load_val  (init_counter),
        .inc       (ctr_inc),
        .count     (core_counter),
        .wrap_pend (ctr_wrap_pend)
    );

    // Decisions taken on the strobe that completes a block. blocks_left still
    // holds the pre-decrement value here, so 1 means "this was the last one".
    assign last_byte = concat_en && (byte_cnt == 6'(BLK_BYTES - 1));
    assign blk_next  = blk_in_buf + BLK_W'(1);
    assign wrap_now  = ctr_wrap_pend && (blocks_left != 16'd1);
    assign last_now  = (blocks_left == 16'd1) || wrap_now;
    assign buf_full  = (int'(blk_next) == NUM_MATRICES);

    // Counter control: load on an accepted start, step on each finished block.
    always_comb begin
        ctr_load = 1'b0;
        ctr_inc  = 1'b0;
        if (state == IDLE && start && num_blocks != 16'd0) begin
            ctr_load = 1'b1;
        end
        if (state == SERIAL && last_byte && !abort) begin
            ctr_inc = 1'b1;
        end
    end

    // Main sequencer; every output is a register written here.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            blk_in_buf  <= '0;
            blocks_left <= '0;
            byte_cnt    <= '0;
            last_buf    <= 1'b0;
            core_start  <= 1'b0;
            load_en     <= 1'b0;
            concat_clr  <= 1'b0;
            ks_valid_q  <= 1'b0;
            ks_last_q   <= 1'b0;
            ks_bytes_q  <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err_ovf     <= 1'b0;
`ifdef CHACHA_KS_PREFETCH_EN
            pend        <= 1'b0;
`endif
        end else begin
            core_start <= 1'b0;
            load_en    <= 1'b0;
            concat_clr <= 1'b0;
            done       <= 1'b0;
            if (abort && state != IDLE) begin
                state      <= IDLE;
                concat_clr <= 1'b1;
                ks_valid_q <= 1'b0;
                ks_last_q  <= 1'b0;
                ks_bytes_q <= '0;
                busy       <= 1'b0;
                blk_in_buf <= '0;
                byte_cnt   <= '0;
`ifdef CHACHA_KS_PREFETCH_EN
                pend       <= 1'b0;
`endif
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            err_ovf <= 1'b0;
                            if (num_blocks != 16'd0) begin
                                blocks_left <= num_blocks;
                                blk_in_buf  <= '0;
                                byte_cnt    <= '0;
                                busy        <= 1'b1;
                                core_start  <= 1'b1;
                                state       <= REQ;
                            end else begin
                                done <= 1'b1;
                            end
                        end
                    end
                    REQ: begin
                        state <= WAIT_CORE;
                    end
                    WAIT_CORE: begin
                        if (core_done) begin
                            load_en <= 1'b1;
                            state   <= LOAD;
                        end
                    end
                    LOAD: begin
                        byte_cnt <= '0;
                        state    <= SERIAL;
                    end
                    SERIAL: begin
                        if (concat_en) begin
                            byte_cnt <= byte_cnt + 6'd1;
                        end
                        if (last_byte) begin
                            blk_in_buf  <= blk_next;
                            blocks_left <= blocks_left - 16'd1;
                            if (buf_full || last_now || concat_full) begin
                                ks_valid_q <= 1'b1;
                                ks_last_q  <= last_now;
                                ks_bytes_q <= BYTES_W'(int'(blk_next) * BLK_BYTES);
                                last_buf   <= last_now;
                                if (wrap_now) begin
                                    err_ovf <= 1'b1;
                                end
`ifdef CHACHA_KS_PREFETCH_EN
                                if (!last_now) begin
                                    core_start <= 1'b1;
                                end
`endif
                                state <= PRESENT;
                            end else begin
                                core_start <= 1'b1;
                                state      <= REQ;
                            end
                        end
                    end
                    PRESENT: begin
`ifdef CHACHA_KS_PREFETCH_EN
                        if (core_done) begin
                            pend <= 1'b1;
                        end
`endif
                        if (ks.ks_ready) begin
                            ks_valid_q <= 1'b0;
                            ks_last_q  <= 1'b0;
                            ks_bytes_q <= '0;
                            concat_clr <= 1'b1;
                            blk_in_buf <= '0;
                            state      <= CLEAR;
                        end
                    end
                    CLEAR: begin
                        if (last_buf) begin
                            busy  <= 1'b0;
                            done  <= !err_ovf;
                            state <= IDLE;
`ifdef CHACHA_KS_PREFETCH_EN
                        end else if (pend || core_done) begin
                            // Prefetched block already finished: skip the request.
                            pend    <= 1'b0;
                            load_en <= 1'b1;
                            state   <= LOAD;
                        end else begin
                            state <= WAIT_CORE;
                        end
`else
                        end else begin
                            core_start <= 1'b1;
                            state      <= REQ;
                        end
`endif
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign ks.ks_valid = ks_valid_q;
    assign ks.ks_last  = ks_last_q;
    assign ks.ks_bytes = ks_bytes_q;

endmodule

// File: tb/tb_chacha_keystream_sequencer.sv
// ---------------------------------------------------------------------------
// tb_chacha_keystream_sequencer
// Directed bench: a table of start vectors run against simple core,
// serialiser and consumer models, plus hand-written sequences for the
// back-pressure stall, abort and reset corner cases.
// ---------------------------------------------------------------------------
module tb_chacha_keystream_sequencer;
    import chacha_pkg::*;

    logic        clk;
    logic        rst;
    logic        start;
    word_t       init_counter;
    logic [15:0] num_blocks;
    logic        abort;
    logic        core_start;
    word_t       core_counter;
    logic        core_done;
    logic        load_en;
    logic        concat_en;
    logic        concat_full;
    logic        concat_clr;
    logic        busy;
    logic        done;
    logic        err_ovf;

    chacha_keystream_sequencer_if #(.BYTES_W(KS_BYTES_W)) ks_bus ();

    chacha_keystream_sequencer dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .init_counter (init_counter),
        .num_blocks   (num_blocks),
        .abort        (abort),
        .core_start   (core_start),
        .core_counter (core_counter),
        .core_done    (core_done),
        .load_en      (load_en),
        .concat_en    (concat_en),
        .concat_full  (concat_full),
        .concat_clr   (concat_clr),
        .ks           (ks_bus),
        .busy         (busy),
        .done         (done),
        .err_ovf      (err_ovf)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int errors = 0;

    bit auto_core  = 1'b1;
    bit auto_ser   = 1'b1;
    bit auto_ready = 1'b1;
    int ser_len    = 64;

    int    cs_cnt;
    int    done_cnt;
    int    clr_cnt;
    int    load_cnt;
    int    buf_cnt;
    word_t cs_ctr [0:15];
    int    buf_bytes [0:15];
    logic  buf_last [0:15];

    typedef struct {
        word_t       ic;
        logic [15:0] nb;
        int          bufs;
        int          bytes0;
        logic        last0;
        int          bytes1;
        int          dones;
        logic        ovf;
        int          starts;
    } vec_t;

    vec_t vecs [7];

    // Core model: answers each request two cycles later.
    initial begin
        core_done = 1'b0;
        forever begin
            @(negedge clk);
            if (auto_core) begin
                core_done = 1'b0;
                if (core_start) begin
                    repeat (2) @(negedge clk);
                    core_done = 1'b1;
                end
            end
        end
    end

    // Serialiser model: ser_len back-to-back byte strobes after each load.
    initial begin
        concat_en = 1'b0;
        forever begin
            @(negedge clk);
            concat_en = 1'b0;
            if (auto_ser && load_en) begin
                for (int i = 0; i < ser_len; i++) begin
                    @(negedge clk);
                    concat_en = 1'b1;
                end
            end
        end
    end

    // Consumer model: records and accepts each buffer immediately.
    initial begin
        ks_bus.ks_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (auto_ready) begin
                ks_bus.ks_ready = 1'b0;
                if (ks_bus.ks_valid) begin
                    if (buf_cnt < 16) begin
                        buf_bytes[buf_cnt] = int'(ks_bus.ks_bytes);
                        buf_last[buf_cnt]  = ks_bus.ks_last;
                    end
                    buf_cnt++;
                    ks_bus.ks_ready = 1'b1;
                end
            end
        end
    end

    // Event monitor.
    initial begin
        forever begin
            @(negedge clk);
            if (core_start) begin
                if (cs_cnt < 16) cs_ctr[cs_cnt] = core_counter;
                cs_cnt++;
            end
            if (done)       done_cnt++;
            if (concat_clr) clr_cnt++;
            if (load_en)    load_cnt++;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clearCounts();
        cs_cnt   = 0;
        done_cnt = 0;
        clr_cnt  = 0;
        load_cnt = 0;
        buf_cnt  = 0;
    endtask

    task automatic applyStimulus(input word_t ic, input logic [15:0] nb, output bit finished);
        clearCounts();
        @(negedge clk);
        init_counter = ic;
        num_blocks   = nb;
        start        = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        finished = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            if (!busy) begin
                finished = 1'b1;
                break;
            end
        end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        bit    fin;
        bit    found;
        int    unstable;
        vec_t  v;

        //           ic            nb  bufs b0   l0 b1  dones ovf starts
        vecs[0] = '{32'h0000_0001, 2,  1,  128, 1, 0,  1,    0,  2};
        vecs[1] = '{32'h0000_0005, 3,  2,  128, 0, 64, 1,    0,  3};
        vecs[2] = '{32'hFFFF_FFFF, 2,  1,  64,  1, 0,  0,    1,  1};
        vecs[3] = '{32'h0000_0007, 1,  1,  64,  1, 0,  1,    0,  1};
        vecs[4] = '{32'hFFFF_FFFF, 1,  1,  64,  1, 0,  1,    0,  1};
        vecs[5] = '{32'h0000_0010, 0,  0,  0,   0, 0,  1,    0,  0};
        vecs[6] = '{32'hFFFF_FFFE, 4,  1,  128, 1, 0,  0,    1,  2};

        rst          = 1'b1;
        start        = 1'b0;
        init_counter = '0;
        num_blocks   = '0;
        abort        = 1'b0;
        concat_full  = 1'b0;
        clearCounts();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("rst_core_start", core_start, 0);
        checkOutput("rst_core_counter", core_counter, 0);
        checkOutput("rst_load_en", load_en, 0);
        checkOutput("rst_ks_valid", ks_bus.ks_valid, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_err_ovf", err_ovf, 0);

        for (int n = 0; n < 7; n++) begin
            v = vecs[n];
            applyStimulus(v.ic, v.nb, fin);
            $display("[TB] vector %0d ic=%0h nb=%0d", n, v.ic, v.nb);
            checkOutput("vec_finished", 32'(fin), 1);
            checkOutput("vec_bufs", buf_cnt, v.bufs);
            if (v.bufs > 0) begin
                checkOutput("vec_bytes0", buf_bytes[0], v.bytes0);
                checkOutput("vec_last0", 32'(buf_last[0]), 32'(v.last0));
            end
            if (v.bufs > 1) begin
                checkOutput("vec_bytes1", buf_bytes[1], v.bytes1);
                checkOutput("vec_last1", 32'(buf_last[1]), 1);
            end
            checkOutput("vec_done", done_cnt, v.dones);
            checkOutput("vec_err_ovf", 32'(err_ovf), 32'(v.ovf));
            checkOutput("vec_core_starts", cs_cnt, v.starts);
            checkOutput("vec_loads", load_cnt, v.starts);
            checkOutput("vec_clears", clr_cnt, v.bufs);
            if (v.starts > 0) begin
                checkOutput("vec_ctr_first", cs_ctr[0], v.ic);
                checkOutput("vec_ctr_last", cs_ctr[v.starts - 1], v.ic + 32'(v.starts - 1));
            end
        end

        // Back-pressure: hold ks_ready low for 20 cycles in PRESENT.
        auto_ready = 1'b0;
        clearCounts();
        @(negedge clk);
        init_counter = 32'h0000_0100;
        num_blocks   = 16'd2;
        start        = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checkOutput("start_to_core_start", core_start, 1);
        checkOutput("start_core_counter", core_counter, 32'h100);
        found = 1'b0;
        for (int c = 0; c < 1000; c++) begin
            @(negedge clk);
            if (ks_bus.ks_valid) begin
                found = 1'b1;
                break;
            end
        end
        checkOutput("stall_reach_present", 32'(found), 1);
        unstable = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (ks_bus.ks_valid !== 1'b1 || ks_bus.ks_bytes !== KS_BYTES_W'(128) || ks_bus.ks_last !== 1'b1)
                unstable++;
        end
        checkOutput("stall_stable", unstable, 0);
        checkOutput("stall_no_core_start", cs_cnt, 2);
        ks_bus.ks_ready = 1'b1;
        @(negedge clk);
        ks_bus.ks_ready = 1'b0;
        checkOutput("stall_concat_clr", concat_clr, 1);
        checkOutput("stall_valid_drop", ks_bus.ks_valid, 0);
        @(negedge clk);
        checkOutput("stall_done", done, 1);
        checkOutput("stall_busy", busy, 0);
        auto_ready = 1'b1;
        repeat (2) @(negedge clk);

        // Abort after 30 bytes of the first block.
        ser_len = 30;
        clearCounts();
        @(negedge clk);
        init_counter = 32'h0000_0001;
        num_blocks   = 16'd2;
        start        = 1'b1;
        @(negedge clk);
        start = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 100; c++) begin
            if (load_en) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        checkOutput("abort_reach_load", 32'(found), 1);
        repeat (31) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checkOutput("abort_concat_clr", concat_clr, 1);
        checkOutput("abort_busy", busy, 0);
        checkOutput("abort_ks_valid", ks_bus.ks_valid, 0);
        repeat (3) @(negedge clk);
        checkOutput("abort_no_done", done_cnt, 0);
        checkOutput("abort_loads", load_cnt, 1);
        ser_len = 64;
        applyStimulus(32'h0000_0009, 16'd1, fin);
        checkOutput("after_abort_finished", 32'(fin), 1);
        checkOutput("after_abort_done", done_cnt, 1);
        checkOutput("after_abort_bufs", buf_cnt, 1);
        checkOutput("after_abort_bytes", buf_bytes[0], 64);
        checkOutput("after_abort_ctr", cs_ctr[0], 32'h9);

        // Reset in WAIT_CORE together with core_done.
        auto_core = 1'b0;
        clearCounts();
        @(negedge clk);
        init_counter = 32'h0000_0020;
        num_blocks   = 16'd1;
        start        = 1'b1;
        @(negedge clk);
        start = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (core_start) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        checkOutput("rst_reach_req", 32'(found), 1);
        @(negedge clk);
        rst       = 1'b1;
        core_done = 1'b1;
        @(negedge clk);
        rst       = 1'b0;
        core_done = 1'b0;
        checkOutput("midrst_core_start", core_start, 0);
        checkOutput("midrst_core_counter", core_counter, 0);
        checkOutput("midrst_load_en", load_en, 0);
        checkOutput("midrst_concat_clr", concat_clr, 0);
        checkOutput("midrst_ks_valid", ks_bus.ks_valid, 0);
        checkOutput("midrst_ks_bytes", 32'(ks_bus.ks_bytes), 0);
        checkOutput("midrst_ks_last", ks_bus.ks_last, 0);
        checkOutput("midrst_busy", busy, 0);
        checkOutput("midrst_done", done, 0);
        checkOutput("midrst_err_ovf", err_ovf, 0);
        repeat (3) @(negedge clk);
        checkOutput("midrst_no_load", load_cnt, 0);
        checkOutput("midrst_idle", busy, 0);
        auto_core = 1'b1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
